// File: rtl/pipeline_pkg.sv
// Shared pipeline control types: next-PC encoding, operand-forward selects and
// the hazard-controller FSM states.
package pipeline_pkg;

    localparam logic [2:0] PC_NEXT    = 3'b000;
    localparam int         WAIT_CNT_W = 16;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_t;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle between the pipeline registers and the hazard controller. The
// pipeline (master) presents stage fields; the hazard unit (slave) returns
// per-stage stall/flush, forward selects, status and perf counters.
import pipeline_pkg::*;

interface hazard_unit_if #(parameter int CNT_WIDTH = 32);
    logic [4:0]           Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
    logic                 MemRead_E;
    logic [2:0]           PCsrc_E;
    logic                 RegWrite_M, RegWrite_W;
    logic                 mem_req_M, mem_ready;
    logic                 stall_F, stall_D, stall_E, stall_M;
    logic                 flush_D, flush_E;
    fwd_t                 ForwardA_E, ForwardB_E;
    logic                 mem_timeout;
    logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;
    hz_state_t            dbg_state;

    modport master (
        output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W, MemRead_E, PCsrc_E,
               RegWrite_M, RegWrite_W, mem_req_M, mem_ready,
        input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E,
               ForwardA_E, ForwardB_E, mem_timeout, stall_cnt, flush_cnt, dbg_state
    );

    modport slave (
        input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W, MemRead_E, PCsrc_E,
               RegWrite_M, RegWrite_W, mem_req_M, mem_ready,
        output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E,
               ForwardA_E, ForwardB_E, mem_timeout, stall_cnt, flush_cnt, dbg_state
    );
endinterface

// File: rtl/forward_sel.sv
// EX-operand forward select for one source register; the MEM producer is
// younger than the WB producer, so it wins when both match.
import pipeline_pkg::*;

module forward_sel (
    input  logic [4:0] rs_i,
    input  logic [4:0] rd_m_i,
    input  logic       regwrite_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       regwrite_w_i,
    output fwd_t       fwd_o
);
    always_comb begin
        fwd_o = FWD_RF;
        if (regwrite_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_i)) begin
            fwd_o = FWD_MEM;
        end else if (regwrite_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_i)) begin
            fwd_o = FWD_WB;
        end
    end
endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: memory-wait sequencing, redirect flushes,
// load-use bubbles, EX forwarding selects and stall/flush perf counters.
import pipeline_pkg::*;

module hazard_unit #(
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_WIDTH    = 32
) (
    input logic          clk,
    input logic          rst_n,
    hazard_unit_if.slave hz
);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LIM = WAIT_CNT_W'(WAIT_TIMEOUT);

    hz_state_t            state_q;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                 mem_timeout_q;
    logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

    logic mem_hold, redirect, load_use, take_redirect;
    logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
    fwd_t fwd_a, fwd_b;

    forward_sel u_fwd_a (
        .rs_i(hz.Rs1_E), .rd_m_i(hz.Rd_M), .regwrite_m_i(hz.RegWrite_M),
        .rd_w_i(hz.Rd_W), .regwrite_w_i(hz.RegWrite_W), .fwd_o(fwd_a)
    );

    forward_sel u_fwd_b (
        .rs_i(hz.Rs2_E), .rd_m_i(hz.Rd_M), .regwrite_m_i(hz.RegWrite_M),
        .rd_w_i(hz.Rd_W), .regwrite_w_i(hz.RegWrite_W), .fwd_o(fwd_b)
    );

    // Once waiting, only mem_ready releases; the request itself need not stay high.
    always_comb begin
        mem_hold      = (state_q == ST_RUN) ? (hz.mem_req_M && !hz.mem_ready) : !hz.mem_ready;
        redirect      = (hz.PCsrc_E != PC_NEXT);
        load_use      = hz.MemRead_E && (hz.Rd_E != 5'd0) &&
                        ((hz.Rd_E == hz.Rs1_D) || (hz.Rd_E == hz.Rs2_D));
        take_redirect = rst_n && !mem_hold && redirect;
        wait_cnt_d    = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + WAIT_CNT_W'(1);

        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (!rst_n) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (mem_hold) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (redirect) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_hold) begin
                        state_q    <= ST_MEM_WAIT;
                        wait_cnt_q <= WAIT_CNT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (hz.mem_ready) begin
                        state_q    <= ST_RUN;
                        wait_cnt_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                        if (wait_cnt_d >= WAIT_LIM) mem_timeout_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_RUN;
                    wait_cnt_q <= '0;
                end
            endcase
            if (stall_f)       stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            if (take_redirect) flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign hz.stall_F     = stall_f;
    assign hz.stall_D     = stall_d;
    assign hz.stall_E     = stall_e;
    assign hz.stall_M     = stall_m;
    assign hz.flush_D     = flush_d;
    assign hz.flush_E     = flush_e;
    assign hz.ForwardA_E  = rst_n ? fwd_a : FWD_RF;
    assign hz.ForwardB_E  = rst_n ? fwd_b : FWD_RF;
    assign hz.mem_timeout = mem_timeout_q;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;
    assign hz.dbg_state   = state_q;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a rule-level model checked every negedge,
// plus hand-computed literal checks along the directed sequence.
import pipeline_pkg::*;

module tb_hazard_unit;
    localparam int WT = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_unit_if #(.CNT_WIDTH(32)) hz ();

    hazard_unit #(.WAIT_TIMEOUT(WT), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .hz(hz)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model state: are we inside a memory wait, how many wait cycles so far, counters.
    bit m_wait = 0;
    int m_run = 0;
    bit m_timeout = 0;
    int m_stall_cnt = 0;
    int m_flush_cnt = 0;
    bit e_wait, e_redirect, e_stall_f;

    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
        if (!rst_n) return 2'b00;
        if (hz.RegWrite_M && hz.Rd_M != 0 && hz.Rd_M == rs) return 2'b10;
        if (hz.RegWrite_W && hz.Rd_W != 0 && hz.Rd_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    always @(negedge clk) begin
        bit lu, lu_taken, rd_any;
        lu = hz.MemRead_E && hz.Rd_E != 0 && (hz.Rd_E == hz.Rs1_D || hz.Rd_E == hz.Rs2_D);
        rd_any = (hz.PCsrc_E != 3'b000);
        e_wait = rst_n && !hz.mem_ready && (m_wait || hz.mem_req_M);
        e_redirect = rst_n && !e_wait && rd_any;
        lu_taken = rst_n && !e_wait && !rd_any && lu;
        e_stall_f = e_wait || lu_taken;
        chk("stall_F", hz.stall_F, e_stall_f);
        chk("stall_D", hz.stall_D, e_stall_f);
        chk("stall_E", hz.stall_E, e_wait);
        chk("stall_M", hz.stall_M, e_wait);
        chk("flush_D", hz.flush_D, !rst_n || e_redirect);
        chk("flush_E", hz.flush_E, !rst_n || e_redirect || lu_taken);
        chk("ForwardA_E", hz.ForwardA_E, model_fwd(hz.Rs1_E));
        chk("ForwardB_E", hz.ForwardB_E, model_fwd(hz.Rs2_E));
        chk("mem_timeout", hz.mem_timeout, rst_n ? m_timeout : 1'b0);
        chk("stall_cnt", hz.stall_cnt, rst_n ? m_stall_cnt : 0);
        chk("flush_cnt", hz.flush_cnt, rst_n ? m_flush_cnt : 0);
        chk("dbg_state", hz.dbg_state, (rst_n && m_wait) ? ST_MEM_WAIT : ST_RUN);
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m_wait = 0; m_run = 0; m_timeout = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            m_wait = e_wait;
            m_run = e_wait ? m_run + 1 : 0;
            if (m_run >= WT) m_timeout = 1;
            if (e_stall_f) m_stall_cnt++;
            if (e_redirect) m_flush_cnt++;
        end
    end

    task automatic idle();
        hz.Rs1_D = 0; hz.Rs2_D = 0; hz.Rs1_E = 0; hz.Rs2_E = 0;
        hz.Rd_E = 0; hz.Rd_M = 0; hz.Rd_W = 0; hz.MemRead_E = 0; hz.PCsrc_E = 3'b000;
        hz.RegWrite_M = 0; hz.RegWrite_W = 0; hz.mem_req_M = 0; hz.mem_ready = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (3) next_cycle();
        #3;
        chk("rst_flush_D", hz.flush_D, 1'b1);
        chk("rst_flush_E", hz.flush_E, 1'b1);
        chk("rst_stall_F", hz.stall_F, 1'b0);
        chk("rst_stall_cnt", hz.stall_cnt, 0);
        next_cycle();
        rst_n = 1'b1;
        #3;
        chk("run_flush_D", hz.flush_D, 1'b0);

        // Forwarding priority.
        next_cycle();
        hz.Rs1_E = 5; hz.Rd_M = 5; hz.RegWrite_M = 1; hz.Rd_W = 5; hz.RegWrite_W = 1;
        #3 chk("fwdA_mem", hz.ForwardA_E, 2'b10);
        next_cycle();
        hz.Rd_M = 0;
        #3 chk("fwdA_wb", hz.ForwardA_E, 2'b01);
        next_cycle();
        hz.Rs1_E = 0;
        #3 chk("fwdA_x0", hz.ForwardA_E, 2'b00);
        next_cycle();
        idle();
        hz.Rs2_E = 3; hz.Rd_M = 3; hz.RegWrite_M = 0; hz.Rd_W = 3; hz.RegWrite_W = 1;
        #3 chk("fwdB_wb", hz.ForwardB_E, 2'b01);

        // Load-use bubble.
        next_cycle();
        idle();
        hz.MemRead_E = 1; hz.Rd_E = 7; hz.Rs2_D = 7;
        #3;
        chk("lu_stall_F", hz.stall_F, 1'b1);
        chk("lu_stall_D", hz.stall_D, 1'b1);
        chk("lu_flush_E", hz.flush_E, 1'b1);
        chk("lu_flush_D", hz.flush_D, 1'b0);
        next_cycle();
        idle();
        hz.MemRead_E = 1; hz.Rd_E = 0; hz.Rs1_D = 0;
        #3;
        chk("lu_x0_stall_F", hz.stall_F, 1'b0);
        chk("lu_stall_cnt", hz.stall_cnt, 1);

        // Redirect beats load-use.
        next_cycle();
        idle();
        hz.PCsrc_E = 3'b001; hz.MemRead_E = 1; hz.Rd_E = 7; hz.Rs1_D = 7;
        #3;
        chk("rd_flush_D", hz.flush_D, 1'b1);
        chk("rd_flush_E", hz.flush_E, 1'b1);
        chk("rd_stall_F", hz.stall_F, 1'b0);
        next_cycle();
        idle();
        #3;
        chk("rd_flush_cnt", hz.flush_cnt, 1);
        chk("rd_stall_cnt", hz.stall_cnt, 1);

        // Memory wait of four cycles; redirect during the wait is ignored.
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            hz.mem_req_M = 1; hz.mem_ready = 0;
            hz.PCsrc_E = (i == 0) ? 3'b000 : 3'b001;
            #3;
            chk("mw_stall_M", hz.stall_M, 1'b1);
            chk("mw_flush_D", hz.flush_D, 1'b0);
        end
        next_cycle();
        hz.PCsrc_E = 3'b000; hz.mem_ready = 1;
        #3 chk("mw_release_stall_F", hz.stall_F, 1'b0);
        next_cycle();
        idle();
        #3;
        chk("mw_stall_cnt", hz.stall_cnt, 5);
        chk("mw_flush_cnt", hz.flush_cnt, 1);
        chk("mw_timeout", hz.mem_timeout, 1'b0);

        // Timeout after the eighth wait cycle, sticky past release.
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            hz.mem_req_M = 1; hz.mem_ready = 0;
            #3 chk("to_flag", hz.mem_timeout, (i >= WT) ? 1'b1 : 1'b0);
        end
        next_cycle();
        hz.mem_ready = 1;
        #3 chk("to_release_stall_E", hz.stall_E, 1'b0);
        next_cycle();
        idle();
        #3;
        chk("to_sticky", hz.mem_timeout, 1'b1);
        chk("to_stall_cnt", hz.stall_cnt, 17);

        // Asynchronous reset in the middle of a wait.
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            hz.mem_req_M = 1; hz.mem_ready = 0;
        end
        next_cycle();
        hz.Rs1_E = 5; hz.Rd_M = 5; hz.RegWrite_M = 1;
        rst_n = 1'b0;
        #3;
        chk("ar_stall_F", hz.stall_F, 1'b0);
        chk("ar_stall_M", hz.stall_M, 1'b0);
        chk("ar_flush_D", hz.flush_D, 1'b1);
        chk("ar_flush_E", hz.flush_E, 1'b1);
        chk("ar_stall_cnt", hz.stall_cnt, 0);
        chk("ar_flush_cnt", hz.flush_cnt, 0);
        chk("ar_timeout", hz.mem_timeout, 1'b0);
        chk("ar_fwdA", hz.ForwardA_E, 2'b00);
        next_cycle();
        rst_n = 1'b1;
        idle();
        #3;
        chk("ar_state_run", hz.dbg_state, ST_RUN);
        chk("ar_run_stall_F", hz.stall_F, 1'b0);

        // Redirect and load-use after reset.
        next_cycle();
        hz.PCsrc_E = 3'b100;
        #3 chk("rd2_flush_D", hz.flush_D, 1'b1);
        next_cycle();
        idle();
        hz.MemRead_E = 1; hz.Rd_E = 12; hz.Rs1_D = 12;
        #3 chk("lu2_stall_D", hz.stall_D, 1'b1);
        next_cycle();
        idle();
        #3;
        chk("end_flush_cnt", hz.flush_cnt, 1);
        chk("end_stall_cnt", hz.stall_cnt, 1);
        next_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
